// File: rtl/litex_plic_pkg.sv
// plic_types: shared word offsets, context encoding and field types for litex_plic.
// Default geometry (16 sources, 3-bit priority) matches the litex_plic parameter defaults.
package plic_types;

    localparam int unsigned PLIC_NUM_SOURCES = 16;
    localparam int unsigned PLIC_PRIO_W      = 3;

    // Word offsets within the 256-word register window (wb_adr[7:0])
    localparam logic [7:0] PRIO_BASE   = 8'h00;
    localparam logic [7:0] PENDING_OFF = 8'h20;
    localparam logic [7:0] ENABLE_OFF  = 8'h40;
    localparam logic [7:0] CTX_OFF     = 8'h80;

    typedef enum logic {
        CTX_M = 1'b0,
        CTX_S = 1'b1
    } ctx_t;

    typedef logic [PLIC_PRIO_W-1:0]               prio_t;
    typedef logic [$clog2(PLIC_NUM_SOURCES)-1:0] id_t;

    // Per-context words are interleaved: threshold at CTX_OFF+2c, claim/complete at CTX_OFF+2c+1
    function automatic logic [7:0] ctx_word(input ctx_t ctx, input logic claim);
        return CTX_OFF + {6'd0, ctx, claim};
    endfunction

endpackage

// File: rtl/litex_plic_target.sv
// plic_target: per-context arbiter. Picks the highest-priority pending, enabled source whose
// priority exceeds the threshold (ties go to the lowest ID) and registers the winner and irq.
// Ports:
//   clk_i, rst_ni  clock, async active-low reset
//   pending_i      pending bits per source (bit 0 ignored)
//   enable_i       enable bits for this context (bit 0 ignored)
//   prio_i         flattened priorities, source i at [i*PRIO_W +: PRIO_W]
//   threshold_i    context threshold
//   best_id_o      registered winning source ID, 0 when none
//   irq_o          registered interrupt request
module plic_target #(
    parameter int unsigned NUM_SOURCES = 16,
    parameter int unsigned PRIO_W      = 3
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NUM_SOURCES-1:0]         pending_i,
    input  logic [NUM_SOURCES-1:0]         enable_i,
    input  logic [NUM_SOURCES*PRIO_W-1:0]  prio_i,
    input  logic [PRIO_W-1:0]              threshold_i,
    output logic [$clog2(NUM_SOURCES)-1:0] best_id_o,
    output logic                           irq_o
);

    localparam int unsigned IdW = $clog2(NUM_SOURCES);

    logic [IdW-1:0]    best_id_d, best_id_q;
    logic [PRIO_W-1:0] best_prio;
    logic              irq_q;

    // Seeding best_prio with the threshold makes "prio > threshold" and "beats current best"
    // the same strict comparison; strictness also yields the lowest-ID tie break.
    always_comb begin
        best_prio = threshold_i;
        best_id_d = '0;
        for (int i = 1; i < NUM_SOURCES; i++) begin
            if (pending_i[i] && enable_i[i] && (prio_i[i*PRIO_W +: PRIO_W] > best_prio)) begin
                best_prio = prio_i[i*PRIO_W +: PRIO_W];
                best_id_d = IdW'(i);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            best_id_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            best_id_q <= best_id_d;
            irq_q     <= (best_id_d != '0);
        end
    end

    assign best_id_o = best_id_q;
    assign irq_o     = irq_q;

    // Source 0 is reserved and never arbitrated
    logic unused_src0;
    assign unused_src0 = ^{pending_i[0], enable_i[0], prio_i[PRIO_W-1:0]};

endmodule

// File: rtl/litex_plic.sv
// litex_plic: platform-level interrupt controller with a Wishbone classic slave.
// Context 0 (M-mode) drives m_irq_o, context 1 (S-mode) drives s_irq_o.
// Optional macro PLIC_SRC_SYNC_EN: when defined, src_i passes through a 2-flop synchronizer
// (gateway latency +2 cycles); when undefined, src_i must be synchronous to clk_i.
// Ports:
//   clk_i, rst_ni        clock, async active-low reset
//   src_i                level interrupt lines (bit 0 ignored)
//   wb_adr_i..wb_we_i    Wishbone classic slave inputs (only wb_adr_i[7:0] decoded)
//   wb_dat_r_o, wb_ack_o registered read data / single-cycle ack; wb_err_o tied 0
//   m_irq_o, s_irq_o     per-context interrupt requests
module litex_plic
    import plic_types::*;
#(
    parameter int unsigned NUM_SOURCES = 16,
    parameter int unsigned PRIO_W      = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NUM_SOURCES-1:0] src_i,
    input  logic [29:0]            wb_adr_i,
    input  logic [31:0]            wb_dat_w_i,
    input  logic [3:0]             wb_sel_i,
    input  logic                   wb_cyc_i,
    input  logic                   wb_stb_i,
    input  logic                   wb_we_i,
    output logic [31:0]            wb_dat_r_o,
    output logic                   wb_ack_o,
    output logic                   wb_err_o,
    output logic                   m_irq_o,
    output logic                   s_irq_o
);

    localparam int unsigned IdW = $clog2(NUM_SOURCES);

    logic [NUM_SOURCES-1:0] src_s;

`ifdef PLIC_SRC_SYNC_EN
    logic [NUM_SOURCES-1:0] sync1_q, sync2_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= src_i;
            sync2_q <= sync1_q;
        end
    end
    assign src_s = sync2_q;
`else
    assign src_s = src_i;
`endif

    logic [NUM_SOURCES*PRIO_W-1:0] prio_d, prio_q;
    logic [NUM_SOURCES-1:0]        pending_d, pending_q, in_flight_d, in_flight_q;
    logic [NUM_SOURCES-1:0]        en_m_d, en_m_q, en_s_d, en_s_q;
    logic [PRIO_W-1:0]             thr_m_d, thr_m_q, thr_s_d, thr_s_q;
    logic                          ack_q;
    logic [31:0]                   dat_r_d, dat_r_q, rdata;
    logic [IdW-1:0]                best_m, best_s;

    logic [7:0] adr;
    logic       req, wr, rd, claim_m, claim_s, complete;

    assign adr      = wb_adr_i[7:0];
    // Side effects happen on the edge that raises ack; the ~ack_q term stops a second hit
    assign req      = wb_cyc_i & wb_stb_i & ~ack_q;
    assign wr       = req & wb_we_i & (wb_sel_i == 4'hF);
    assign rd       = req & ~wb_we_i;
    assign claim_m  = rd & (adr == ctx_word(CTX_M, 1'b1));
    assign claim_s  = rd & (adr == ctx_word(CTX_S, 1'b1));
    assign complete = wr & ((adr == ctx_word(CTX_M, 1'b1)) | (adr == ctx_word(CTX_S, 1'b1)));

    always_comb begin
        rdata = '0;
        for (int i = 1; i < NUM_SOURCES; i++) begin
            if (adr == PRIO_BASE + 8'(i)) rdata[PRIO_W-1:0] = prio_q[i*PRIO_W +: PRIO_W];
        end
        case (adr)
            PENDING_OFF:              rdata[NUM_SOURCES-1:0] = pending_q;
            ENABLE_OFF:               rdata[NUM_SOURCES-1:0] = en_m_q;
            ENABLE_OFF + 8'd1:        rdata[NUM_SOURCES-1:0] = en_s_q;
            ctx_word(CTX_M, 1'b0):    rdata[PRIO_W-1:0]      = thr_m_q;
            ctx_word(CTX_M, 1'b1):    rdata[IdW-1:0]         = best_m;
            ctx_word(CTX_S, 1'b0):    rdata[PRIO_W-1:0]      = thr_s_q;
            ctx_word(CTX_S, 1'b1):    rdata[IdW-1:0]         = best_s;
            default: ;
        endcase
    end

    always_comb begin
        prio_d      = prio_q;
        en_m_d      = en_m_q;
        en_s_d      = en_s_q;
        thr_m_d     = thr_m_q;
        thr_s_d     = thr_s_q;
        in_flight_d = in_flight_q;
        dat_r_d     = rd ? rdata : 32'd0;

        // Gateway: a high line pends unless the source is already pending or being serviced
        pending_d    = pending_q | (src_s & ~in_flight_q);
        pending_d[0] = 1'b0;

        if (wr) begin
            case (adr)
                ENABLE_OFF:            en_m_d  = wb_dat_w_i[NUM_SOURCES-1:0] & ~NUM_SOURCES'(1);
                ENABLE_OFF + 8'd1:     en_s_d  = wb_dat_w_i[NUM_SOURCES-1:0] & ~NUM_SOURCES'(1);
                ctx_word(CTX_M, 1'b0): thr_m_d = wb_dat_w_i[PRIO_W-1:0];
                ctx_word(CTX_S, 1'b0): thr_s_d = wb_dat_w_i[PRIO_W-1:0];
                default: ;
            endcase
        end

        for (int i = 1; i < NUM_SOURCES; i++) begin
            if (wr && adr == PRIO_BASE + 8'(i)) prio_d[i*PRIO_W +: PRIO_W] = wb_dat_w_i[PRIO_W-1:0];
            // Claim overrides the gateway set in the same cycle
            if ((claim_m && best_m == IdW'(i)) || (claim_s && best_s == IdW'(i))) begin
                pending_d[i]   = 1'b0;
                in_flight_d[i] = 1'b1;
            end
            // Out-of-range IDs match no i and fall through harmlessly
            if (complete && wb_dat_w_i == 32'(i)) in_flight_d[i] = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q      <= '0;
            pending_q   <= '0;
            in_flight_q <= '0;
            en_m_q      <= '0;
            en_s_q      <= '0;
            thr_m_q     <= '0;
            thr_s_q     <= '0;
            ack_q       <= 1'b0;
            dat_r_q     <= '0;
        end else begin
            prio_q      <= prio_d;
            pending_q   <= pending_d;
            in_flight_q <= in_flight_d;
            en_m_q      <= en_m_d;
            en_s_q      <= en_s_d;
            thr_m_q     <= thr_m_d;
            thr_s_q     <= thr_s_d;
            ack_q       <= req;
            dat_r_q     <= dat_r_d;
        end
    end

    plic_target #(
        .NUM_SOURCES(NUM_SOURCES),
        .PRIO_W     (PRIO_W)
    ) u_target_m (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .pending_i  (pending_q),
        .enable_i   (en_m_q),
        .prio_i     (prio_q),
        .threshold_i(thr_m_q),
        .best_id_o  (best_m),
        .irq_o      (m_irq_o)
    );

    plic_target #(
        .NUM_SOURCES(NUM_SOURCES),
        .PRIO_W     (PRIO_W)
    ) u_target_s (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .pending_i  (pending_q),
        .enable_i   (en_s_q),
        .prio_i     (prio_q),
        .threshold_i(thr_s_q),
        .best_id_o  (best_s),
        .irq_o      (s_irq_o)
    );

    assign wb_dat_r_o = dat_r_q;
    assign wb_ack_o   = ack_q;
    assign wb_err_o   = 1'b0;

    logic unused_adr;
    assign unused_adr = ^wb_adr_i[29:8];

endmodule

// File: doc/litex_plic.md
Name: litex_plic

Overview:
- Platform-level interrupt controller feeding the CPU wrapper's cpu_m_interrupt / cpu_s_interrupt inputs.
- Collects level-sensitive peripheral interrupt lines through per-source gateways.
- Arbitrates pending sources per context: context 0 = M-mode, context 1 = S-mode.
- Exposes a Wishbone classic slave so the core programs priorities, enables and thresholds, and claims/completes interrupts over the peripheral bus.

Parameters:
- NUM_SOURCES, 16: source count including reserved source 0; range 2..32.
- PRIO_W, 3: priority field width; priority 0 = never interrupts.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- src  in  NUM_SOURCES  level interrupt lines; bit 0 ignored
- wb_adr  in  30  word address; only wb_adr[7:0] decoded
- wb_dat_w  in  32  write data
- wb_sel  in  4  byte selects; writes require wb_sel==4'hF, otherwise ignored
- wb_cyc  in  1  cycle
- wb_stb  in  1  strobe
- wb_we  in  1  write enable
- wb_dat_r  out  32  read data
- wb_ack  out  1  acknowledge
- wb_err  out  1  tied 0
- m_irq  out  1  context 0 interrupt request
- s_irq  out  1  context 1 interrupt request

Behaviour:
- Reset: all outputs 0; all priority, pending, in_flight, enable and threshold state 0; best_id registers 0.
- Word map (wb_adr[7:0]):
  - 0x01..NUM_SOURCES-1: priority[i], RW, bits [PRIO_W-1:0].
  - 0x20: pending, RO.
  - 0x40: enable ctx0, RW.
  - 0x41: enable ctx1, RW.
  - 0x80: threshold ctx0, RW.
  - 0x81: claim/complete ctx0.
  - 0x82: threshold ctx1, RW.
  - 0x83: claim/complete ctx1.
  - Unmapped reads, word 0, and bit 0 of pending/enable all read 0. Unused high bits read 0. Unmapped writes are ignored.
- Bus handshake:
  - wb_ack <= wb_cyc & wb_stb & ~wb_ack, so one transaction takes 2 cycles and ack is a single-cycle pulse.
  - wb_dat_r is registered, valid with ack, and 0 otherwise.
  - Register writes and claim/complete side effects occur on the edge that raises ack.
  - Dropping cyc before ack aborts the access with no side effect.
- Gateway, per source i≥1, on each edge:
  - If src_s[i] & ~in_flight[i] & ~pending[i], set pending[i].
  - src_s is the sampled source line (see Optional Feature).
- Target selection, per context c:
  - Candidates are sources with pending & enable_c & (priority > threshold_c).
  - best_id_c is registered: the highest priority candidate, ties broken by lowest ID, 0 if no candidate.
  - irq_c <= (best_id_c_next != 0).
  - Latency: pending set at edge E, irq asserted at edge E+1.
- Claim (read of a claim word):
  - Returns the current registered best_id_c.
  - If that ID is nonzero: clear pending[id], set in_flight[id].
  - ID 0 has no side effect.
- Complete (write of a claim word with data D):
  - If 0 < D < NUM_SOURCES and in_flight[D]: clear in_flight[D].
  - Otherwise ignored, with no error.
- Simultaneous events:
  - Claim and gateway set on the same source in the same cycle: the claim wins. The source is in_flight and is not re-pended.
  - Complete while the line is still high: pending sets on the following edge.
  - Writing priority to 0 or disabling a source does not clear pending. It only removes the source from arbitration.
- Reset asserted mid-transaction: all state clears asynchronously and ack drops immediately. The master must restart the access.

Optional Feature:
- Macro PLIC_SRC_SYNC_EN.
- Defined: src passes through a 2-flop synchronizer per bit, src_s = second flop. Gateway latency is +2 cycles; use for asynchronous peripheral domains.
- Undefined: src_s = src directly, and src must be synchronous to clk.

Decomposition:
- Package plic_types holds:
  - Word-offset constants: PRIO_BASE, PENDING_OFF, ENABLE_OFF, CTX_OFF.
  - typedef ctx_t (CTX_M=0, CTX_S=1).
  - The prio_t typedef and the id_t typedef ($clog2(NUM_SOURCES) bits).
- Sub-module plic_target: combinational max-priority/lowest-ID selector plus best_id/irq registers. It is instantiated once per context.

Test Plan:
- Reset then idle reads → all map words read 0, m_irq=s_irq=0, every ack is one cycle wide.
- prio[3]=2, enable0=0x0008, thr0=1, raise src[3] → m_irq=1 two edges after src_s rises. Claim0 read returns 3, m_irq drops next cycle, pending[3]=0. With src held high, no re-pend until complete(3), then m_irq reasserts.
- prio[5]=4, prio[2]=4, prio[7]=6, all enabled ctx1, all raised → claims return 7, then 2, then 5 (completing each between claims); a fourth claim returns 0.
- thr1=4, prio[9]=4, enable1 bit 9 set → s_irq stays 0. Set thr1=3 → s_irq=1 next edge.
- Complete writes of 0, 20, and a non-in-flight ID → no state change. Write with wb_sel=4'h3 → ignored, still acked.
- Assert rst during the ack cycle of a claim → all state 0 at once. After release, a claim read returns 0 with no side effect.
